// File: rtl/sw_conditioner.sv
// rtl/sw_conditioner.sv - per-channel button synchronizer, debouncer, press pulse and hold-to-repeat FSM
module sw_conditioner #(
  parameter int NUM_SW       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int LONG_CNT     = 50000000,
  parameter int REPEAT_CNT   = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_btn,
  output logic [NUM_SW-1:0] o_sw_pulse,
  output logic [NUM_SW-1:0] o_sw_level,
  output logic [NUM_SW-1:0] o_sw_long
);

  localparam int TM_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int DB_W   = $clog2(DEBOUNCE_CNT);
  localparam int TM_W   = $clog2(TM_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [TM_W-1:0] LONG_LAST = TM_W'(LONG_CNT - 1);
  localparam logic [TM_W-1:0] RPT_LAST  = TM_W'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} state_t;

  logic [NUM_SW-1:0] p;
  logic [NUM_SW-1:0] s1;
  logic [NUM_SW-1:0] s2;

  // Normalise so that 1 always means pressed; reset then equals "released".
  assign p = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  for (genvar k = 0; k < NUM_SW; k++) begin : g_ch
    logic [DB_W-1:0] db_cnt;
    logic [TM_W-1:0] tm;
    logic            level_q;
    logic            pulse_q;
    logic            long_q;
    state_t          state;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (s2[k] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= s2[k];
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    // A release seen in the same cycle as a timer expiry takes priority.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= S_IDLE;
        tm      <= '0;
        pulse_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          S_IDLE: begin
            if (level_q) begin
              state   <= S_HOLD;
              tm      <= '0;
              pulse_q <= 1'b1;
            end
          end
          S_HOLD: begin
            if (!level_q) begin
              state <= S_IDLE;
            end else if (tm == LONG_LAST) begin
              state   <= S_RPT;
              tm      <= '0;
              pulse_q <= 1'b1;
              long_q  <= 1'b1;
            end else begin
              tm <= tm + TM_W'(1);
            end
          end
          S_RPT: begin
            if (!level_q) begin
              state  <= S_IDLE;
              long_q <= 1'b0;
            end else if (tm == RPT_LAST) begin
              tm      <= '0;
              pulse_q <= 1'b1;
            end else begin
              tm <= tm + TM_W'(1);
            end
          end
          default: begin
            state  <= S_IDLE;
            long_q <= 1'b0;
          end
        endcase
      end
    end

    assign o_sw_pulse[k] = pulse_q;
    assign o_sw_level[k] = level_q;
    assign o_sw_long[k]  = long_q;
  end

endmodule
